cnt_capture_fifo: RTL

- Downstream consumer of the free-running 8-bit counter stage clocked on clk1.
- Each cycle it captures qualified counter samples into a first-word-fall-through (FWFT) FIFO.
- It presents the samples to a sink with a valid/ready handshake and counts samples dropped on overflow.
- It sits between the counter/data source and the channel formatter, and isolates sink back-pressure from the free-running source.

---
 rtl/cnt_cap_pkg.sv | 11 +
 rtl/cnt_seq_checker.sv | 38 +++
 rtl/cnt_capture_fifo.sv | 105 ++++++++++
 3 files changed

// File: rtl/cnt_cap_pkg.sv
// Shared types and constants for the counter-sample capture path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cnt_cap_pkg;

    typedef logic [7:0] sample_t;

    localparam int        CNT_CAP_DEPTH_DEF = 8;
    localparam logic [7:0] DROP_CNT_MAX     = 8'hFF;

endpackage

// File: rtl/cnt_seq_checker.sv
// Continuity checker: flags any qualified sample that is not previous sample + 1 (mod 2^DW).
// Latency: seq_err pulses for one cycle on the edge after the offending sample.
// Backpressure: none; observes every din_valid sample, including ones the FIFO drops.
module cnt_seq_checker #(
    parameter int DW = 8
) (
    input  logic          clk1,
    input  logic          rstn,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          seq_err
);

    logic [DW-1:0] r_prev;
    logic          r_have_prev;
    logic          r_seq_err;
    logic [DW-1:0] w_expect;

    // Expected next value wraps naturally at the DW-bit boundary.
    assign w_expect = r_prev + DW'(1);
    assign seq_err  = r_seq_err;

    // Track the last sample and raise a single-cycle pulse on a break; first sample is never checked.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_seq_err <= din_valid && r_have_prev && (din != w_expect);
            if (din_valid) begin
                r_prev      <= din;
                r_have_prev <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_capture_fifo.sv
// Captures qualified counter samples into a first-word-fall-through FIFO for a valid/ready sink.
// Latency: a sample pushed at edge N is on dout after edge N (zero bubble into an empty FIFO).
// Backpressure: sink stalls fill the FIFO; when full, new samples are dropped and counted (saturating).
// Build option: define CNT_CAPTURE_SEQ_CHECK_EN to enable the sample continuity checker (seq_err).
module cnt_capture_fifo
    import cnt_cap_pkg::*;
#(
    parameter int  DW    = 8,
    parameter int  DEPTH = CNT_CAP_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk1,
    input  logic          rstn,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    output logic [DW-1:0] dout,
    input  logic          dout_ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt,
    output logic          seq_err
);

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_drop_cnt;

    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status comes only from registered occupancy, never from din_valid/dout_ready.
    assign full       = (r_count == L_FULL);
    assign empty      = (r_count == '0);
    assign dout_valid = !empty;
    assign dout       = empty ? '0 : r_mem[r_rd_ptr];
    assign count      = r_count;
    assign drop_cnt   = r_drop_cnt;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts when the sink drains.
    assign w_pop  = dout_valid && dout_ready;
    assign w_push = din_valid && (!full || w_pop);
    assign w_drop = din_valid && full && !w_pop;

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap at DEPTH for free because DEPTH is a power of two.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop counter sticks at its maximum until the next reset.
    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef CNT_CAPTURE_SEQ_CHECK_EN
    cnt_seq_checker #(
        .DW (DW)
    ) u_seq_checker (
        .clk1      (clk1),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din       (din),
        .seq_err   (seq_err)
    );
`else
    assign seq_err = 1'b0;
`endif

endmodule
